// File: rtl/bsg_manycore_host_req_arbiter.sv
// rtl/bsg_manycore_host_req_arbiter.sv - round-robin host request arbiter with credit tracking and id-routed responses
module bsg_manycore_host_req_arbiter #(
  parameter int num_req_p         = 4,
  parameter int data_width_p      = 128,
  parameter int max_out_credits_p = 16,
  localparam int id_width_lp      = $clog2(num_req_p),
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              reset_done_i,
  input  logic                              drain_i,
  output logic                              drained_o,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              link_req_v_o,
  output logic [data_width_p-1:0]           link_req_data_o,
  output logic [id_width_lp-1:0]            link_req_id_o,
  input  logic                              link_req_ready_i,
  input  logic                              link_rsp_v_i,
  input  logic [data_width_p-1:0]           link_rsp_data_i,
  input  logic [id_width_lp-1:0]            link_rsp_id_i,
  output logic                              link_rsp_ready_o,
  output logic [num_req_p-1:0]              rsp_v_o,
  output logic [data_width_p-1:0]           rsp_data_o,
  input  logic [num_req_p-1:0]              rsp_ready_i,
  output logic [credit_width_lp-1:0]        credits_used_o,
  output logic                              error_o
);

  typedef enum logic [1:0] {
    S_WAIT_RESET = 2'd0,
    S_RUN        = 2'd1,
    S_DRAIN      = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [id_width_lp-1:0]     rr_q, rr_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic                       error_q, error_d;

  logic [id_width_lp-1:0]     winner;
  logic                       found;
  logic                       eligible;
  logic                       req_hs;
  logic                       rsp_id_ok;
  logic                       rsp_hs;
  logic                       credit_dec;

  // Rotating-priority scan starting at the round-robin pointer.
  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_q;
    found  = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(rr_q) + k) % num_req_p;
      if (!found && req_v_i[idx]) begin
        found  = 1'b1;
        winner = id_width_lp'(idx);
      end
    end
  end

  always_comb begin
    eligible        = (state_q == S_RUN) &&
                      (credits_q < credit_width_lp'(max_out_credits_p));
    link_req_v_o    = eligible && (|req_v_i);
    link_req_id_o   = winner;
    link_req_data_o = req_data_i[int'(winner)*data_width_p +: data_width_p];
    req_ready_o     = '0;
    if (link_req_v_o) begin
      req_ready_o[winner] = link_req_ready_i;
    end
    req_hs = link_req_v_o && link_req_ready_i;
  end

  // Out-of-range ids are swallowed (ready forced high) so the link never wedges.
  always_comb begin
    rsp_v_o          = '0;
    link_rsp_ready_o = 1'b1;
    rsp_id_ok        = 1'b0;
    rsp_data_o       = link_rsp_data_i;
    for (int i = 0; i < num_req_p; i++) begin
      if (link_rsp_id_i == id_width_lp'(i)) begin
        rsp_id_ok        = 1'b1;
        rsp_v_o[i]       = link_rsp_v_i;
        link_rsp_ready_o = rsp_ready_i[i];
      end
    end
    rsp_hs     = link_rsp_v_i && link_rsp_ready_o;
    credit_dec = rsp_hs && rsp_id_ok && (credits_q != '0);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    credits_d = credits_q;
    error_d   = error_q;

    unique case (state_q)
      S_WAIT_RESET: if (reset_done_i) state_d = S_RUN;
      S_RUN:        if (drain_i)      state_d = S_DRAIN;
      S_DRAIN:      if (!drain_i)     state_d = S_RUN;
      default:                        state_d = S_WAIT_RESET;
    endcase

    if (req_hs) begin
      rr_d = (winner == id_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end

    unique case ({req_hs, credit_dec})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase

    if (rsp_hs && (!rsp_id_ok || (credits_q == '0))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_WAIT_RESET;
      rr_q      <= '0;
      credits_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      credits_q <= credits_d;
      error_q   <= error_d;
    end
  end

  assign drained_o      = (state_q == S_DRAIN) && (credits_q == '0);
  assign credits_used_o = credits_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// tb/tb_bsg_manycore_host_req_arbiter.sv - randomized self-checking bench with behavioural model
module tb_bsg_manycore_host_req_arbiter;

  localparam int N   = 4;
  localparam int W   = 128;
  localparam int MAX = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            reset_done = 1'b0;
  logic            drain = 1'b0;
  logic            drained;
  logic [N-1:0]    req_v = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic            link_req_v;
  logic [W-1:0]    link_req_data;
  logic [1:0]      link_req_id;
  logic            link_req_ready = 1'b0;
  logic            link_rsp_v = 1'b0;
  logic [W-1:0]    link_rsp_data = '0;
  logic [1:0]      link_rsp_id = '0;
  logic            link_rsp_ready;
  logic [N-1:0]    rsp_v;
  logic [W-1:0]    rsp_data;
  logic [N-1:0]    rsp_ready = '0;
  logic [4:0]      credits_used;
  logic            error;

  logic            d3_drained;
  logic [2:0]      d3_req_ready;
  logic            d3_link_req_v;
  logic [7:0]      d3_link_req_data;
  logic [1:0]      d3_link_req_id;
  logic            d3_link_rsp_v = 1'b0;
  logic [1:0]      d3_link_rsp_id = '0;
  logic            d3_link_rsp_ready;
  logic [2:0]      d3_rsp_v;
  logic [7:0]      d3_rsp_data;
  logic [2:0]      d3_credits;
  logic            d3_error;

  always #5 clk = ~clk;

  bsg_manycore_host_req_arbiter #(
    .num_req_p(N), .data_width_p(W), .max_out_credits_p(MAX)
  ) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .reset_done_i(reset_done),
    .drain_i(drain), .drained_o(drained),
    .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
    .link_req_v_o(link_req_v), .link_req_data_o(link_req_data),
    .link_req_id_o(link_req_id), .link_req_ready_i(link_req_ready),
    .link_rsp_v_i(link_rsp_v), .link_rsp_data_i(link_rsp_data),
    .link_rsp_id_i(link_rsp_id), .link_rsp_ready_o(link_rsp_ready),
    .rsp_v_o(rsp_v), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
    .credits_used_o(credits_used), .error_o(error)
  );

  bsg_manycore_host_req_arbiter #(
    .num_req_p(3), .data_width_p(8), .max_out_credits_p(4)
  ) u_dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .reset_done_i(1'b0),
    .drain_i(1'b0), .drained_o(d3_drained),
    .req_v_i(3'b000), .req_data_i(24'h0), .req_ready_o(d3_req_ready),
    .link_req_v_o(d3_link_req_v), .link_req_data_o(d3_link_req_data),
    .link_req_id_o(d3_link_req_id), .link_req_ready_i(1'b0),
    .link_rsp_v_i(d3_link_rsp_v), .link_rsp_data_i(8'h5a),
    .link_rsp_id_i(d3_link_rsp_id), .link_rsp_ready_o(d3_link_rsp_ready),
    .rsp_v_o(d3_rsp_v), .rsp_data_o(d3_rsp_data), .rsp_ready_i(3'b000),
    .credits_used_o(d3_credits), .error_o(d3_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting for reset done, 1 = running, 2 = draining.
  int m_mode = 0;
  int m_rr = 0;
  int m_credits = 0;
  bit m_err = 1'b0;
  int out_q[$];
  int grant_log[$];
  int hs_count = 0;
  int max_seen = 0;

  int           e_win;
  bit           e_link_v;
  logic [N-1:0] e_ready;
  bit           e_id_ok;
  logic [N-1:0] e_rsp_v;
  bit           e_lrr;
  bit           e_drained;

  always_comb begin
    bit fnd;
    fnd   = 1'b0;
    e_win = m_rr;
    for (int k = 0; k < N; k++) begin
      if (!fnd && req_v[(m_rr + k) % N]) begin
        fnd   = 1'b1;
        e_win = (m_rr + k) % N;
      end
    end
    e_link_v  = (m_mode == 1) && (m_credits < MAX) && (req_v != '0);
    e_ready   = (e_link_v && link_req_ready) ? N'(1 << e_win) : '0;
    e_id_ok   = int'(link_rsp_id) < N;
    e_rsp_v   = (e_id_ok && link_rsp_v) ? N'(1 << link_rsp_id) : '0;
    e_lrr     = e_id_ok ? rsp_ready[link_rsp_id] : 1'b1;
    e_drained = (m_mode == 2) && (m_credits == 0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_rr = 0; m_credits = 0; m_err = 1'b0;
      out_q.delete();
    end else begin
      bit rq, rs, idok;
      int w, rid;
      rq = e_link_v && link_req_ready;
      rs = link_rsp_v && e_lrr;
      idok = e_id_ok;
      w = e_win;
      rid = int'(link_rsp_id);
      if (rs && (!idok || m_credits == 0)) m_err = 1'b1;
      if (rs && idok && m_credits > 0) begin
        m_credits--;
        for (int i = 0; i < out_q.size(); i++) begin
          if (out_q[i] == rid) begin
            out_q.delete(i);
            break;
          end
        end
      end
      if (rq) begin
        m_credits++;
        out_q.push_back(w);
        grant_log.push_back(w);
        hs_count++;
        m_rr = (w + 1) % N;
      end
      case (m_mode)
        0: if (reset_done) m_mode = 1;
        1: if (drain) m_mode = 2;
        2: if (!drain) m_mode = 1;
        default: m_mode = 0;
      endcase
      if (m_credits > max_seen) max_seen = m_credits;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_link_v", link_req_v, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_credits", credits_used, 0);
      check("rst_error", error, 0);
      check("rst_drained", drained, 0);
    end else begin
      check("link_req_v", link_req_v, e_link_v);
      check("req_ready", req_ready, e_ready);
      if (e_link_v) begin
        check("link_req_id", link_req_id, e_win);
        check("link_req_data", link_req_data, req_data[e_win*W +: W]);
      end
      check("rsp_v", rsp_v, e_rsp_v);
      check("link_rsp_ready", link_rsp_ready, e_lrr);
      check("rsp_data", rsp_data, link_rsp_data);
      check("credits", credits_used, m_credits);
      check("error", error, m_err);
      check("drained", drained, e_drained);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
    link_rsp_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rsp_front();
    link_rsp_v = (out_q.size() > 0);
    link_rsp_id = (out_q.size() > 0) ? 2'(out_q[0]) : 2'd0;
  endtask

  task automatic drain_all();
    req_v = '0;
    rsp_ready = '1;
    for (int c = 0; c < 40 && out_q.size() > 0; c++) begin
      rsp_front();
      tick();
    end
    link_rsp_v = 1'b0;
  endtask

  initial begin
    int exp_order[6];
    int base;
    exp_order = '{0, 1, 2, 3, 0, 1};

    repeat (3) tick();
    reset_n = 1'b1;
    req_v = '1;
    link_req_ready = 1'b1;
    rsp_ready = '1;
    repeat (10) tick();
    check("wait_link_v", link_req_v, 0);
    check("wait_req_ready", req_ready, 0);

    grant_log.delete();
    reset_done = 1'b1;
    tick();
    check("first_grant_v", link_req_v, 1);
    check("first_grant_id", link_req_id, 0);

    for (int c = 0; c < 40 && grant_log.size() < 6; c++) begin
      rsp_front();
      tick();
    end
    check("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp_order[i]);
    check("rr_credit_le1", max_seen <= 1, 1);
    drain_all();
    check("rr_credits_zero", credits_used, 0);

    base = hs_count;
    req_v = '1;
    repeat (30) tick();
    check("cap_handshakes", hs_count - base, 16);
    check("cap_link_v", link_req_v, 0);
    check("cap_credits", credits_used, 16);
    rsp_front();
    tick();
    link_rsp_v = 1'b0;
    repeat (5) tick();
    check("cap_one_more", hs_count - base, 17);
    drain_all();

    req_v = 4'b0100;
    tick();
    req_v = '0;
    link_rsp_v = 1'b1;
    link_rsp_id = 2'd2;
    rsp_ready = '0;
    #1;
    check("id2_rsp_v", rsp_v, 4'b0100);
    check("id2_lrr_low", link_rsp_ready, 0);
    tick();
    check("id2_credit_held", credits_used, 1);
    rsp_ready = 4'b0100;
    #1;
    check("id2_lrr_high", link_rsp_ready, 1);
    tick();
    link_rsp_v = 1'b0;
    rsp_ready = '1;
    check("id2_credit_dec", credits_used, 0);

    req_v = '1;
    repeat (3) tick();
    req_v = '0;
    drain = 1'b1;
    tick();
    req_v = '1;
    repeat (3) tick();
    check("drain_no_grant", link_req_v, 0);
    check("drain_not_done", drained, 0);
    check("drain_credits", credits_used, 3);
    for (int c = 0; c < 3; c++) begin
      rsp_front();
      tick();
    end
    link_rsp_v = 1'b0;
    #1;
    check("drain_done", drained, 1);
    drain = 1'b0;
    tick();
    check("resume_v", link_req_v, 1);
    check("resume_id", link_req_id, 2);
    drain_all();

    link_rsp_v = 1'b1;
    link_rsp_id = 2'd0;
    d3_link_rsp_v = 1'b1;
    d3_link_rsp_id = 2'd3;
    #1;
    check("d3_badid_ready", d3_link_rsp_ready, 1);
    check("d3_badid_rsp_v", d3_rsp_v, 0);
    tick();
    link_rsp_v = 1'b0;
    d3_link_rsp_v = 1'b0;
    check("underflow_err", error, 1);
    check("underflow_credits", credits_used, 0);
    check("d3_badid_err", d3_error, 1);
    repeat (5) tick();
    check("err_sticky", error, 1);
    reset_n = 1'b0;
    #1;
    check("err_cleared", error, 0);
    check("d3_err_cleared", d3_error, 0);
    tick();
    reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      req_v = N'($urandom);
      link_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) drain = ~drain;
      if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        link_rsp_v = 1'b1;
        link_rsp_id = 2'(out_q[$urandom_range(0, out_q.size() - 1)]);
      end else begin
        link_rsp_v = 1'b0;
        link_rsp_id = 2'($urandom);
      end
      rsp_ready = N'($urandom);
      reset_n = (c != 1500);
      if (c == 1500) link_rsp_v = 1'b0;
      tick();
    end
    reset_n = 1'b1;
    drain = 1'b0;
    drain_all();
    check("final_credits", credits_used, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
